mux_arb: RTL and testbench
==========================

Name: mux_arb

Overview:
- Parametrised N:1 registered multiplexer for W-bit channels with a per-channel valid/ready handshake.
- Two modes:
  - fixed-select: an external selector picks the channel.
  - round-robin: the block arbitrates fairly among valid channels.
- The output is a one-entry holding register with valid/ready. It feeds downstream lab datapaths that previously used a bare combinational select.

Parameters:
- N_INPUTS, 32, number of input channels (>= 2).
- WIDTH, 1, data bits per channel.
- SEL_W, $clog2(N_INPUTS), selector/grant index width. This is a derived localparam and is not overridable.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- data_i  input  N_INPUTS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- valid_i  input  N_INPUTS  per-channel data valid.
- ready_o  output  N_INPUTS  per-channel accept; at most one bit high per cycle.
- mode_i  input  1  0 = fixed-select, 1 = round-robin.
- sel_i  input  SEL_W  channel index used in fixed-select mode.
- out_data_o  output  WIDTH  registered selected data.
- out_sel_o  output  SEL_W  index of the channel whose data is held.
- out_valid_o  output  1  holding register contains a word.
- out_ready_i  input  1  downstream accept.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - out_valid_o=0, out_data_o=0, out_sel_o=0.
  - RR pointer last_q=N_INPUTS-1, so the first RR search starts at channel 0.
  - ready_o is forced to 0 in any cycle where rst_i=1.
  - Reset mid-transfer discards the held word; no handshake completes that cycle.
- Load enable: load = !out_valid_o || out_ready_i. The register accepts a new word in the same cycle the old one drains, giving full throughput of 1 word/cycle.
- Grant (combinational from current inputs and state):
  - Fixed mode: grant to sel_i iff sel_i < N_INPUTS and valid_i[sel_i]=1. If sel_i >= N_INPUTS, there is no grant.
  - RR mode: grant to the first k with valid_i[k]=1, searching from (last_q+1) mod N_INPUTS upward with wrap-around. If no channel is valid, there is no grant.
- ready_o[g] = load && grant_valid for the granted channel g only. All other bits are 0.
- Transfer: occurs when valid_i[g] && ready_o[g]. At the next edge:
  - out_data_o <= channel g data, out_sel_o <= g, out_valid_o <= 1.
  - In RR mode, last_q <= g.
- Drain without refill: when out_ready_i=1 and there is no grant, out_valid_o <= 0 at the next edge. out_data_o and out_sel_o hold their last values.
- Stall: while out_valid_o=1 and out_ready_i=0, out_data_o, out_sel_o and out_valid_o are stable, and all ready_o bits are 0.
- Latency: exactly 1 cycle from input transfer to out_valid_o.
- last_q updates only on an RR-mode transfer. Fixed-mode transfers leave it unchanged.
- Mode or sel_i changes take effect on the next grant evaluation. A word already held is unaffected.
- Inputs may change freely when there is no transfer. Upstream must not drop valid before ready; the bench checks this and the RTL does not depend on it.

Decomposition:
- Package mux_arb_pkg holds:
  - mode enum (MODE_FIXED=1'b0, MODE_RR=1'b1);
  - a function for the packed-slice index.
- Sub-module rr_pick (N_INPUTS, SEL_W): combinational rotate-priority search. It takes a request vector and a start pointer, and returns a grant index plus a grant-valid flag. It is instantiated once.

Test Plan:
- Reset, then fixed mode, N=32, W=1, sel_i=5, valid_i[5]=1, data ch5=1, out_ready_i=1 -> ready_o=32'h20 in that cycle; next cycle out_valid_o=1, out_data_o=1, out_sel_o=5.
- Fixed mode, sel_i=7, valid_i[7]=0 with other channels valid -> ready_o=0, out_valid_o falls to 0 after the held word drains.
- RR mode, W=8, valid_i={ch3,ch10,ch31} continuously, out_ready_i=1 -> grant order 3,10,31,3,10,... (wrap past 31 to 3), with one output per cycle and data matching the source channel.
- Backpressure: out_ready_i=0 for 4 cycles with a word held (data 8'hA5, sel 10) -> out_data_o=8'hA5 and out_sel_o=10 stable, all ready_o=0; release -> next grant proceeds in the same cycle.
- Mode switch RR->fixed after a grant to ch10, then back to RR -> fixed transfers do not move last_q, and the next RR grant searches from ch11.
- rst_i asserted for 1 cycle while out_valid_o=1 and stalled -> next cycle out_valid_o=0, out_data_o=0, ready_o=0 during reset; first RR grant after reset goes to the lowest valid channel.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the mux_arb block.
package mux_arb_pkg;

    // Arbitration mode carried on mode_i.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Low bit of channel k inside a packed vector of w-bit channels.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Rotate-priority search: first requesting index at or above i_start, wrapping.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N_INPUTS = 32,
    parameter int SEL_W    = $clog2(N_INPUTS)
) (
    input  logic [N_INPUTS-1:0] i_req,
    input  logic [SEL_W-1:0]    i_start,
    output logic [SEL_W-1:0]    o_gnt,
    output logic                o_gnt_valid
);

    int               w_sum;
    logic [SEL_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt       = '0;
        o_gnt_valid = 1'b0;
        w_sum       = 0;
        w_idx       = '0;
        for (int off = N_INPUTS - 1; off >= 0; off--) begin
            w_sum = int'(i_start) + off;
            if (w_sum >= N_INPUTS) begin
                w_sum = w_sum - N_INPUTS;
            end
            w_idx = SEL_W'(w_sum);
            if (i_req[w_idx]) begin
                o_gnt       = w_idx;
                o_gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// N:1 registered multiplexer with fixed-select or round-robin arbitration.
//
// Handshake: on every channel (input k and the output) a word moves on a
// rising edge where valid and ready are both high. Valid never waits for
// ready; ready_o is driven only from state and current inputs. The output
// holding register reloads in the same cycle it drains (load enable
// = !out_valid_o || out_ready_i), so throughput is one word per cycle.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int N_INPUTS = 32,
    parameter int WIDTH    = 1,
    localparam int SEL_W   = $clog2(N_INPUTS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_INPUTS*WIDTH-1:0] data_i,
    input  logic [N_INPUTS-1:0]       valid_i,
    output logic [N_INPUTS-1:0]       ready_o,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [WIDTH-1:0]          out_data_o,
    output logic [SEL_W-1:0]          out_sel_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_last;

    mode_e               w_mode;
    logic                w_load;
    logic [SEL_W-1:0]    w_rr_start;
    logic [SEL_W-1:0]    w_rr_gnt;
    logic                w_rr_valid;
    logic                w_sel_in_range;
    logic                w_fix_valid;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic                w_gnt_valid;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_gnt_data;
    logic [N_INPUTS-1:0] w_ready;

    assign w_mode = mode_e'(mode_i);
    assign w_load = !r_out_valid || out_ready_i;

    // Search begins one past the last RR winner; reset value makes it start at 0.
    assign w_rr_start = (r_last == SEL_W'(N_INPUTS - 1)) ? '0 : r_last + SEL_W'(1);

    rr_pick #(
        .N_INPUTS (N_INPUTS),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .i_req       (valid_i),
        .i_start     (w_rr_start),
        .o_gnt       (w_rr_gnt),
        .o_gnt_valid (w_rr_valid)
    );

    // Selector values beyond the last channel never grant.
    assign w_sel_in_range = ({1'b0, sel_i} < (SEL_W + 1)'(N_INPUTS));
    assign w_fix_valid    = w_sel_in_range && valid_i[sel_i];

    assign w_gnt_idx   = (w_mode == MODE_RR) ? w_rr_gnt   : sel_i;
    assign w_gnt_valid = (w_mode == MODE_RR) ? w_rr_valid : w_fix_valid;

    // A transfer needs a grant, room in the holding register, and no reset.
    assign w_xfer = w_gnt_valid && w_load && !rst_i;

    // Select the granted channel's data and raise its ready bit only.
    always_comb begin
        w_gnt_data = '0;
        w_ready    = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (w_gnt_idx == SEL_W'(k)) begin
                w_gnt_data = data_i[slice_lo(k, WIDTH) +: WIDTH];
                w_ready[k] = w_xfer;
            end
        end
    end

    assign ready_o = w_ready;

    // Holding register and RR pointer; drain without refill keeps data/sel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_last      <= SEL_W'(N_INPUTS - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt_idx;
            if (w_mode == MODE_RR) begin
                r_last <= w_gnt_idx;
            end
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data_o  = r_out_data;
    assign out_sel_o   = r_out_sel;
    assign out_valid_o = r_out_valid;

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: directed scenarios followed by random traffic.
module tb_mux_arb;

    localparam int N  = 32;
    localparam int W  = 8;
    localparam int SW = 5;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N*W-1:0]  data_i;
    logic [N-1:0]    valid_i;
    logic [N-1:0]    ready_o;
    logic            mode_i;
    logic [SW-1:0]   sel_i;
    logic [W-1:0]    out_data_o;
    logic [SW-1:0]   out_sel_o;
    logic            out_valid_o;
    logic            out_ready_i;

    logic [W-1:0]    ch_data [N];
    logic [W+SW-1:0] exp_q[$];
    int              checks = 0;
    int              errors = 0;

    // reference model state
    bit              m_valid = 1'b0;
    logic [W-1:0]    m_data  = '0;
    logic [SW-1:0]   m_sel   = '0;
    int              m_last  = N - 1;
    int              m_xfer_ch;
    logic [N-1:0]    pend;

    mux_arb #(.N_INPUTS(N), .WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .mode_i      (mode_i),
        .sel_i       (sel_i),
        .out_data_o  (out_data_o),
        .out_sel_o   (out_sel_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    // clock
    always #5 clk = ~clk;

    always_comb begin
        data_i = '0;
        for (int k = 0; k < N; k++) data_i[k*W +: W] = ch_data[k];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs, check against the model, advance the model.
    task automatic cycle(input bit rst, input bit md, input int sel, input bit ordy,
                         input logic [N-1:0] vld);
        int           g;
        bit           gv;
        logic [N-1:0] exp_rdy;
        rst_i       = rst;
        mode_i      = md;
        sel_i       = SW'(sel);
        out_ready_i = ordy;
        valid_i     = vld;
        @(negedge clk);
        gv = 1'b0;
        g  = 0;
        if (!md) begin
            if (sel < N && vld[sel]) begin gv = 1'b1; g = sel; end
        end else begin
            for (int o = 1; o <= N; o++) begin
                int k;
                k = (m_last + o) % N;
                if (vld[k]) begin gv = 1'b1; g = k; break; end
            end
        end
        exp_rdy   = '0;
        m_xfer_ch = -1;
        if (!rst && (!m_valid || ordy) && gv) exp_rdy[g] = 1'b1;
        check("ready_o", 64'(ready_o), 64'(exp_rdy));
        check("out_valid_o", 64'(out_valid_o), 64'(m_valid));
        check("out_data_o", 64'(out_data_o), 64'(m_data));
        check("out_sel_o", 64'(out_sel_o), 64'(m_sel));
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_sel = '0; m_last = N - 1;
            exp_q.delete();
        end else if (exp_rdy != 0) begin
            exp_q.push_back({ch_data[g], SW'(g)});
            m_valid = 1'b1; m_data = ch_data[g]; m_sel = SW'(g);
            m_xfer_ch = g;
            if (md) m_last = g;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output word must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_i === 1'b0 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'({out_data_o, out_sel_o}), 64'hdead);
            end else begin
                check("out_word", 64'({out_data_o, out_sel_o}), 64'(exp_q.pop_front()));
            end
        end
    end

    logic [N-1:0] v3;

    initial begin
        v3 = '0;
        v3[3] = 1'b1; v3[10] = 1'b1; v3[31] = 1'b1;
        for (int k = 0; k < N; k++) ch_data[k] = W'(k + 8'h40);
        rst_i = 1'b1; mode_i = 1'b0; sel_i = '0; out_ready_i = 1'b0; valid_i = '0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, '0);

        // fixed select of channel 5
        ch_data[5] = 8'h01;
        cycle(0, 0, 5, 1, 32'h20);
        // selected channel 7 idle while others request: word drains, nothing refills
        cycle(0, 0, 7, 1, ~32'h80);
        cycle(0, 0, 7, 1, ~32'h80);

        // round-robin over 3, 10, 31 with wrap
        ch_data[3] = 8'h33; ch_data[10] = 8'hA5; ch_data[31] = 8'h1F;
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 1, v3);
        // next winner is 10 (data A5); then stall for 4 cycles
        cycle(0, 1, 0, 1, v3);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, v3);
        // release: next grant in the same cycle
        cycle(0, 1, 0, 1, v3);

        // last winner 31; get to 10, then fixed transfers, then back to RR
        cycle(0, 1, 0, 1, v3);
        cycle(0, 1, 0, 1, v3);
        cycle(0, 0, 3, 1, v3);
        cycle(0, 0, 31, 1, v3);
        cycle(0, 1, 0, 1, v3);
        cycle(0, 1, 0, 1, v3);

        // reset while a word is held and stalled
        cycle(0, 1, 0, 0, v3);
        cycle(1, 1, 0, 0, v3);
        cycle(0, 1, 0, 1, v3);
        cycle(0, 1, 0, 1, '0);

        // random traffic: a channel keeps valid and data until it is accepted
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1'b1;
                    ch_data[k] = W'($urandom);
                end
            end
            cycle(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                  ($urandom_range(0, 3) != 0), pend);
            if (m_xfer_ch >= 0) pend[m_xfer_ch] = 1'b0;
        end

        // drain
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, '0);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
